// File: rtl/dlatch_bank_pkg.sv
// Shared types and constants for the dlatch_bank latch-bank slice.
package dlatch_bank_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_END
    } bank_state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    // Age counter width; never narrower than one bit so HOLD_MAX=0 still elaborates.
    function automatic int age_width(input int hold_max);
        return (hold_max > 0) ? $clog2(hold_max + 1) : 1;
    endfunction

endpackage

// File: rtl/dlatch_chan.sv
// One latch channel: held data, valid flag, saturating age counter and enable-edge history.
module dlatch_chan
    import dlatch_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               HOLD_MAX  = 15,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             flush_wr,
    input  logic             mode,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             stale
);

    localparam int AW = age_width(HOLD_MAX);
    localparam logic [AW-1:0] AGE_MAX = AW'(HOLD_MAX);

    logic          en_prev;
    logic [AW-1:0] age;
    logic          capture;

    assign capture = cap_en && en && ((mode == MODE_LEVEL) || !en_prev);

    // NOTE: every flop here, including en_prev, is cleared by the synchronous
    // reset so an enable held high across reset is seen as a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            valid   <= 1'b0;
            age     <= '0;
            en_prev <= 1'b0;
        end else begin
            en_prev <= en;
            if (flush_wr) begin
                q     <= FLUSH_VAL;
                valid <= 1'b0;
                age   <= '0;
            end else if (capture) begin
                q     <= d;
                valid <= 1'b1;
                age   <= '0;
            end else if (valid && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end

    assign stale = valid && (age == AGE_MAX);

endmodule

// File: rtl/dlatch_bank.sv
// Bank of CHANNELS clocked latch channels with a sequenced flush walker.
module dlatch_bank
    import dlatch_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter int               HOLD_MAX  = 15,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      mode,
    input  logic                      flush_req,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] qb,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       stale,
    output logic                      flush_ack,
    output logic                      busy
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(CHANNELS - 1);

    bank_state_t   state;
    logic [PW-1:0] ptr;
    logic          run;

    // NOTE: flush_ack is defaulted low at the top of the block and only raised
    // on the FLUSH->END transition, so it is high for exactly the END cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= 1'b0;
            case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    if (flush_req) begin
                        state <= S_FLUSH;
                        ptr   <= '0;
                    end
                end
                S_FLUSH: begin
                    if (ptr == PTR_LAST) begin
                        state     <= S_END;
                        flush_ack <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_END:   state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign run  = (state == S_RUN);
    assign busy = !run;
    assign qb   = ~q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic flush_wr;
        assign flush_wr = (state == S_FLUSH) && (ptr == PW'(c));

        dlatch_chan #(
            .WIDTH    (WIDTH),
            .HOLD_MAX (HOLD_MAX),
            .FLUSH_VAL(FLUSH_VAL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .cap_en  (run),
            .flush_wr(flush_wr),
            .mode    (mode),
            .en      (en[c]),
            .d       (d[c*WIDTH +: WIDTH]),
            .q       (q[c*WIDTH +: WIDTH]),
            .valid   (valid[c]),
            .stale   (stale[c])
        );
    end

endmodule

// File: tb/tb_dlatch_bank.sv
// Self-checking bench for dlatch_bank (WIDTH=8, CHANNELS=4, HOLD_MAX=15, FLUSH_VAL=0).
module tb_dlatch_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic [31:0] d;
    logic        mode;
    logic        flush_req;
    logic [31:0] q;
    logic [31:0] qb;
    logic [3:0]  valid;
    logic [3:0]  stale;
    logic        flush_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic [31:0] d;
        logic        mode;
        logic        fr;
        logic [31:0] q;
        logic [3:0]  valid;
        logic [3:0]  stale;
        logic        busy;
        logic        ack;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] q;
        logic [3:0]  valid;
        logic [3:0]  stale;
        logic        busy;
        logic        ack;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];

    dlatch_bank #(
        .WIDTH    (8),
        .CHANNELS (4),
        .HOLD_MAX (15),
        .FLUSH_VAL(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d        (d),
        .mode     (mode),
        .flush_req(flush_req),
        .q        (q),
        .qb       (qb),
        .valid    (valid),
        .stale    (stale),
        .flush_ack(flush_ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        rst       = v.rst;
        en        = v.en;
        d         = v.d;
        mode      = v.mode;
        flush_req = v.fr;
        e.tag   = tag;
        e.q     = v.q;
        e.valid = v.valid;
        e.stale = v.stale;
        e.busy  = v.busy;
        e.ack   = v.ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".q"},     q,                 got.q);
        check({got.tag, ".qb"},    qb,                ~got.q);
        check({got.tag, ".valid"}, {28'd0, valid},    {28'd0, got.valid});
        check({got.tag, ".stale"}, {28'd0, stale},    {28'd0, got.stale});
        check({got.tag, ".busy"},  {31'd0, busy},     {31'd0, got.busy});
        check({got.tag, ".ack"},   {31'd0, flush_ack}, {31'd0, got.ack});
    endtask

    task automatic step(input logic r, input logic [3:0] e_in, input logic [31:0] d_in,
                        input logic m, input logic fr, input logic [31:0] eq,
                        input logic [3:0] ev, input logic [3:0] es, input logic eb,
                        input logic ea, input string tag);
        vec_t v;
        v = '{r, e_in, d_in, m, fr, eq, ev, es, eb, ea};
        apply(v, tag);
    endtask

    initial begin
        rst = 1'b1; en = '0; d = '0; mode = 1'b0; flush_req = 1'b0;

        // reset with toggling inputs, then level mode on ch0, then edge mode on ch1
        tbl[0]  = '{1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        4'h0, 4'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'hA, 32'h12345678, 1'b0, 1'b1, 32'h0,        4'h0, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'h1, 32'h00000011, 1'b0, 1'b0, 32'h00000011, 4'h1, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'h1, 32'h00000022, 1'b0, 1'b0, 32'h00000022, 4'h1, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'h1, 32'h00000033, 1'b0, 1'b0, 32'h00000033, 4'h1, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 32'h00000044, 1'b0, 1'b0, 32'h00000033, 4'h1, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'h2, 32'h0000A500, 1'b1, 1'b0, 32'h0000A533, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'h2, 32'h00005A00, 1'b1, 1'b0, 32'h0000A533, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'h2, 32'h00005A00, 1'b1, 1'b0, 32'h0000A533, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'h2, 32'h00005A00, 1'b1, 1'b0, 32'h0000A533, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 32'h00005A00, 1'b1, 1'b0, 32'h0000A533, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'h2, 32'h00005A00, 1'b1, 1'b0, 32'h00005A33, 4'h3, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h00005A33, 4'h3, 4'h0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // age saturation: ch0..2 captured together, stale from the 15th idle cycle on
        step(1'b0, 4'h7, 32'h00C3B2A1, 1'b0, 1'b0, 32'h00C3B2A1, 4'h7, 4'h0, 1'b0, 1'b0, "age_cap");
        for (int i = 1; i <= 20; i++)
            step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h00C3B2A1, 4'h7,
                 (i >= 15) ? 4'h7 : 4'h0, 1'b0, 1'b0, $sformatf("age%0d", i));
        step(1'b0, 4'h4, 32'h003C0000, 1'b0, 1'b0, 32'h003CB2A1, 4'h7, 4'h3, 1'b0, 1'b0, "age_recap");

        // flush walk: channels cleared in order, en edge during flush is consumed
        step(1'b0, 4'h8, 32'hD4000000, 1'b0, 1'b0, 32'hD43CB2A1, 4'hF, 4'h3, 1'b0, 1'b0, "fl_fill");
        step(1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hD43CB2A1, 4'hF, 4'h3, 1'b1, 1'b0, "fl_req");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'hD43CB200, 4'hE, 4'h2, 1'b1, 1'b0, "fl_c0");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'hD43C0000, 4'hC, 4'h0, 1'b1, 1'b0, "fl_c1");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'hD4000000, 4'h8, 4'h0, 1'b1, 1'b0, "fl_c2");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'h0,        4'h0, 4'h0, 1'b1, 1'b1, "fl_c3");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, "fl_end");
        step(1'b0, 4'h1, 32'h000000FF, 1'b1, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, "fl_held");
        step(1'b0, 4'h0, 32'h000000FF, 1'b1, 1'b0, 32'h0,        4'h0, 4'h0, 1'b0, 1'b0, "fl_drop");
        step(1'b0, 4'h1, 32'h000000EE, 1'b1, 1'b0, 32'h000000EE, 4'h1, 4'h0, 1'b0, 1'b0, "fl_recap");

        // held flush_req re-triggers a second flush on return to RUN
        for (int i = 0; i < 7; i++)
            step(1'b0, 4'h0, 32'h0, 1'b0, 1'b1,
                 (i == 0) ? 32'h000000EE : 32'h0, (i == 0) ? 4'h1 : 4'h0, 4'h0,
                 (i != 5), (i == 4), $sformatf("rt%0d", i));
        step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0, "rt_drain");
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, (i < 3), (i == 2),
                 $sformatf("rt_tail%0d", i));

        // reset during the second flush cycle: no flush_ack afterwards
        step(1'b0, 4'hF, 32'h01020304, 1'b0, 1'b0, 32'h01020304, 4'hF, 4'h0, 1'b0, 1'b0, "rs_fill");
        step(1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'h01020304, 4'hF, 4'h0, 1'b1, 1'b0, "rs_req");
        step(1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 32'h01020300, 4'hE, 4'h0, 1'b1, 1'b0, "rs_c0");
        step(1'b1, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 4'h0, 1'b1, 1'b0, "rs_rst");
        for (int i = 0; i < 6; i++)
            step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0,
                 $sformatf("rs_after%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
